// File: rtl/wir_building.sv
// Wrapper instruction register: serial shift/capture stage on WRCK rising edge,
// parallel update stage on WRCK falling edge, decoded into the boundary-path select.
module wir_building #(
    parameter int WIR_LEN = 3
) (
    input  logic WRCK_input,
    input  logic wir_capture,
    input  logic wir_shift,
    input  logic wir_update,
    input  logic WRCK,
    input  logic resetn,
    input  logic WRSTN,
    output logic wir_so,
    output logic wir_ctrl_output
);

    typedef enum logic [1:0] {
        WS_BYPASS  = 2'd0,
        WS_EXTEST  = 2'd1,
        WS_INTEST  = 2'd2,
        WS_PRELOAD = 2'd3
    } wir_instr_e;

    logic [WIR_LEN-1:0] sr_q, sr_d;
    logic [WIR_LEN-1:0] ur_q, ur_d;
    wir_instr_e         instr;

    // Capture wins over shift; the soft clear blocks both on the same edge.
    always_comb begin
        sr_d = sr_q;
        if (!resetn) begin
            sr_d = '0;
        end else if (wir_capture) begin
            sr_d = ur_q;
        end else if (wir_shift) begin
            sr_d = {WRCK_input, sr_q[WIR_LEN-1:1]};
        end
    end

    always_comb begin
        ur_d = ur_q;
        if (!resetn) begin
            ur_d = '0;
        end else if (wir_update) begin
            ur_d = sr_q;
        end
    end

    always_ff @(posedge WRCK or posedge WRSTN) begin
        if (WRSTN) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    // Update on the falling edge so it sees the value shifted on the preceding rising edge.
    always_ff @(negedge WRCK or posedge WRSTN) begin
        if (WRSTN) begin
            ur_q <= '0;
        end else begin
            ur_q <= ur_d;
        end
    end

    // Codes above 3 are reserved and fall back to bypass.
    always_comb begin
        instr = WS_BYPASS;
        if (ur_q <= WIR_LEN'(3)) begin
            instr = wir_instr_e'(ur_q[1:0]);
        end
    end

    assign wir_so          = sr_q[0];
    assign wir_ctrl_output = (instr != WS_BYPASS);

endmodule

// File: tb/tb_wir_building.sv
// Scoreboard bench for wir_building: each driven cycle pushes the expected wir_so
// (after the rising edge) and wir_ctrl_output (after the falling edge).
module tb_wir_building;

    logic WRCK_input, wir_capture, wir_shift, wir_update;
    logic WRCK, resetn, WRSTN;
    logic wir_so, wir_ctrl_output;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic  so;
        logic  ctrl;
        string tag;
    } exp_t;
    exp_t sb[$];

    logic [2:0] m_sr, m_ur;

    wir_building #(.WIR_LEN(3)) dut (
        .WRCK_input      (WRCK_input),
        .wir_capture     (wir_capture),
        .wir_shift       (wir_shift),
        .wir_update      (wir_update),
        .WRCK            (WRCK),
        .resetn          (resetn),
        .WRSTN           (WRSTN),
        .wir_so          (wir_so),
        .wir_ctrl_output (wir_ctrl_output)
    );

    initial begin
        WRCK = 1'b0;
        forever #5 WRCK = ~WRCK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // One full WRCK cycle; called just after a falling edge.
    task automatic cycle(input logic din, input logic cap, input logic sh,
                         input logic upd, input logic rn, input string tag);
        logic [2:0] nsr, nur;
        exp_t e, got;
        WRCK_input  = din;
        wir_capture = cap;
        wir_shift   = sh;
        wir_update  = upd;
        resetn      = rn;
        nsr = m_sr;
        if (!rn)      nsr = 3'b000;
        else if (cap) nsr = m_ur;
        else if (sh)  nsr = {din, m_sr[2:1]};
        nur = m_ur;
        if (!rn)      nur = 3'b000;
        else if (upd) nur = nsr;
        m_sr = nsr;
        m_ur = nur;
        e.so   = nsr[0];
        e.ctrl = (nur == 3'd1) || (nur == 3'd2) || (nur == 3'd3);
        e.tag  = tag;
        sb.push_back(e);
        @(posedge WRCK);
        #1;
        checks++;
        if (wir_so !== sb[0].so) begin
            errors++;
            $display("FAIL %s so: got %b expected %b", sb[0].tag, wir_so, sb[0].so);
        end
        @(negedge WRCK);
        #1;
        got = sb.pop_front();
        checks++;
        if (wir_ctrl_output !== got.ctrl) begin
            errors++;
            $display("FAIL %s ctrl: got %b expected %b", got.tag, wir_ctrl_output, got.ctrl);
        end
        $display("cycle %-10s din=%b cap=%b sh=%b upd=%b rn=%b so=%b ctrl=%b",
                 tag, din, cap, sh, upd, rn, wir_so, wir_ctrl_output);
    endtask

    task automatic idle_inputs();
        WRCK_input = 1'b0; wir_capture = 1'b0; wir_shift = 1'b0;
        wir_update = 1'b0; resetn = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        WRSTN = 1'b1;
        #1;
        checks++;
        if (wir_so !== 1'b0 || wir_ctrl_output !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got so=%b ctrl=%b expected 0 0", wir_so, wir_ctrl_output);
        end
        // Inputs are ignored while reset is held across edges.
        wir_shift = 1'b1; WRCK_input = 1'b1; wir_update = 1'b1;
        @(posedge WRCK); #1;
        @(negedge WRCK); #1;
        checks++;
        if (wir_so !== 1'b0 || wir_ctrl_output !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got so=%b ctrl=%b expected 0 0", wir_so, wir_ctrl_output);
        end
        idle_inputs();
        WRSTN = 1'b0;
        m_sr = 3'b000;
        m_ur = 3'b000;
        $display("reset done so=%b ctrl=%b", wir_so, wir_ctrl_output);
    endtask

    task automatic load_ur(input logic [2:0] code, input string tag);
        // Bits enter at the MSB, so shift code[0] first.
        for (int i = 0; i < 3; i++) cycle(code[i], 1'b0, 1'b1, 1'b0, 1'b1, tag);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, {tag, "_upd"});
    endtask

    task automatic test_shift_update();
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "sh1");
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "sh0a");
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "sh0b");
        checks++;
        if (wir_so !== 1'b1) begin
            errors++;
            $display("FAIL shift_001_so: got %b expected 1", wir_so);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "upd001");
        checks++;
        if (wir_ctrl_output !== 1'b1) begin
            errors++;
            $display("FAIL upd001_ctrl: got %b expected 1", wir_ctrl_output);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "hold");
    endtask

    task automatic test_capture();
        load_ur(3'b010, "ld010");
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "junk");
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "cap_pri");
        checks++;
        if (wir_so !== 1'b0) begin
            errors++;
            $display("FAIL capture_so: got %b expected 0", wir_so);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "cap_sh");
        checks++;
        if (wir_so !== 1'b1) begin
            errors++;
            $display("FAIL capture_shift_so: got %b expected 1", wir_so);
        end
    endtask

    task automatic test_reserved();
        load_ur(3'b101, "ld101");
        checks++;
        if (wir_ctrl_output !== 1'b0) begin
            errors++;
            $display("FAIL reserved101_ctrl: got %b expected 0", wir_ctrl_output);
        end
        load_ur(3'b011, "ld011");
        load_ur(3'b111, "ld111");
        load_ur(3'b100, "ld100");
    endtask

    task automatic test_back_to_back();
        test_reset();
        @(negedge WRCK); #1;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] iv;
            iv = 4'(i);
            cycle(iv[1], 1'b0, 1'b1, 1'b1, 1'b1, $sformatf("b2b%0d", i));
        end
    endtask

    task automatic test_soft_clear();
        load_ur(3'b001, "ld001");
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "pre_sc");
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "softclr");
        checks++;
        if (wir_so !== 1'b0 || wir_ctrl_output !== 1'b0) begin
            errors++;
            $display("FAIL soft_clear: got so=%b ctrl=%b expected 0 0", wir_so, wir_ctrl_output);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "cap_after");
    endtask

    task automatic test_async_mid_shift();
        load_ur(3'b011, "ld011b");
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "ms1");
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "ms2");
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "ms3");
        wir_shift = 1'b1;
        WRCK_input = 1'b1;
        #2;
        WRSTN = 1'b1;
        #1;
        checks++;
        if (wir_so !== 1'b0 || wir_ctrl_output !== 1'b0) begin
            errors++;
            $display("FAIL async_mid_shift: got so=%b ctrl=%b expected 0 0", wir_so, wir_ctrl_output);
        end
        $display("async reset mid-shift so=%b ctrl=%b", wir_so, wir_ctrl_output);
        @(negedge WRCK); #1;
        WRSTN = 1'b0;
        m_sr = 3'b000;
        m_ur = 3'b000;
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "post_rst");
    endtask

    initial begin
        idle_inputs();
        WRSTN = 1'b0;
        test_reset();
        @(negedge WRCK); #1;
        test_shift_update();
        test_capture();
        test_reserved();
        test_back_to_back();
        test_soft_clear();
        test_async_mid_shift();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
